mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port unified memory of the multi-cycle RISC-V core. It shares the memory between the instruction-fetch requester (read-only, I port) and the load/store requester (read/write, D port). It serialises one transaction at a time, returns read data with a one-cycle valid pulse, and keeps per-port grant counters for the test bench.

## Interface
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- MEM_LAT, 2, memory read latency in cycles (legal 1..4).
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held high with stable i_addr until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  one-cycle pulse, fetch request accepted.
- i_rvalid  out  1  one-cycle pulse, i_rdata valid.
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held high with stable fields until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_gnt  out  1  one-cycle pulse, data request accepted.
- d_rvalid  out  1  one-cycle pulse, d_rdata valid (loads only).
- d_rdata  out  DATA_W  load data.
- mem_cs  out  1  memory select, one cycle per transaction.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables; all ones on reads.
- mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after the mem_cs cycle.
- busy  out  1  high in every state except IDLE.
- i_cnt  out  16  fetch grants issued, saturating at 0xFFFF.
- d_cnt  out  16  data grants issued, saturating at 0xFFFF.

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP. Encoding is free.
- IDLE: samples i_req and d_req at the clock edge.
  - Neither asserted: stay in IDLE.
  - One asserted: that port wins.
  - Both asserted: the port that is not last_owner wins.
  - The winner's command is registered and the FSM goes to ISSUE.
- last_owner register resets to I, so D wins the first contention. It then alternates under sustained contention.
- ISSUE (one cycle): mem_cs=1. mem_we/addr/wdata/be come from the registered command. The winner's gnt=1, its counter increments, and last_owner is updated.
  - Store: next state is IDLE.
  - Load or fetch: next state is WAIT.
- WAIT: lasts MEM_LAT cycles. mem_rdata is registered on the last WAIT cycle. Next state is RESP.
- RESP (one cycle): owner's rvalid=1 and owner's rdata holds the captured word. Next state is IDLE.
- rdata of each port holds its last value between responses.
- Request signals are ignored outside IDLE. A req dropped before gnt is a protocol violation, but behaviour must stay safe: if req is low at the IDLE sample, no transaction occurs.
- No mem_* output may toggle except in ISSUE. mem_cs and mem_we are 0 in all other states.

## Timing
- Reset (rstn low, asynchronous):
  - state = IDLE, last_owner = I.
  - All outputs 0, including rdata, counters and mem_*.
  - Any in-flight transaction is abandoned. No rvalid follows, even if memory returns data after reset is released.
- Request sampled high at edge e: gnt and mem_cs are high in cycle e+1 (ISSUE, cycle c).
- Read: mem_rdata sampled in cycle c+MEM_LAT, rvalid in cycle c+MEM_LAT+1, IDLE in c+MEM_LAT+2.
  - Back-to-back reads from one port: one ISSUE every MEM_LAT+3 cycles.
- Store: IDLE in cycle c+1, next ISSUE no earlier than c+2.
- gnt and rvalid of a port are never high in the same cycle.
- Only one gnt is high per cycle, and only one rvalid is high per cycle.
- Counter saturation: at 0xFFFF further grants leave the count unchanged. The grant itself still proceeds.

## Test plan
- Reset: drive rstn=0 mid-WAIT of a fetch. Required: all outputs 0 immediately. After release, no i_rvalid, and i_cnt=0.
- Single fetch, MEM_LAT=2: i_req with i_addr=0x40, memory returns 0x00500093. Required: i_gnt/mem_cs in cycle c with mem_addr=0x40, i_rvalid in c+3 with i_rdata=0x00500093, busy low in c+4.
- Store: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011. Required: one ISSUE cycle with mem_we=1 and mem_be=4'b0011, no d_rvalid, IDLE the following cycle.
- Contention: i_req and d_req held high continuously after reset. Required: grants D, I, D, I in order; i_cnt=2 and d_cnt=2 after four transactions.
- Load latency sweep: MEM_LAT=1 and MEM_LAT=4, load from 0x8 returning 0x12345678. Required: d_rvalid exactly MEM_LAT+1 cycles after d_gnt, with correct data.
- Saturation: preload 65535 fetch grants (or force i_cnt=0xFFFE, then issue 2 grants). Required: i_cnt stays at 0xFFFF and the fetch still completes.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one single-port memory between the fetch (I) and
// load/store (D) requesters; one transaction in flight, alternating on contention.
//
// state | meaning
// IDLE  | sample i_req/d_req, register the winner's command
// ISSUE | drive mem_cs for one cycle, pulse the winner's gnt
// WAIT  | MEM_LAT cycles for read data, captured on the last one
// RESP  | pulse the owner's rvalid
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_cs,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic [15:0]         i_cnt,
    output logic [15:0]         d_cnt
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    logic [1:0]        state_q,      state_d;
    logic              owner_q,      owner_d;
    logic              last_owner_q, last_owner_d;
    logic              cmd_we_q,     cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q,   cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q,  cmd_wdata_d;
    logic [BE_W-1:0]   cmd_be_q,     cmd_be_d;
    logic [2:0]        wait_cnt_q,   wait_cnt_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic [15:0]       i_cnt_q,      i_cnt_d;
    logic [15:0]       d_cnt_q,      d_cnt_d;
    logic              pick_d;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_be_d     = cmd_be_q;
        wait_cnt_d   = wait_cnt_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_cnt_d      = i_cnt_q;
        d_cnt_d      = d_cnt_q;
        pick_d       = d_req & (~i_req | (last_owner_q == OWN_I));

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_d = S_ISSUE;
                    if (pick_d) begin
                        owner_d     = OWN_D;
                        cmd_we_d    = d_we;
                        cmd_addr_d  = d_addr;
                        cmd_wdata_d = d_wdata;
                        cmd_be_d    = d_we ? d_be : {BE_W{1'b1}};
                    end else begin
                        // write data is left untouched so mem_wdata stays quiet on fetches
                        owner_d    = OWN_I;
                        cmd_we_d   = 1'b0;
                        cmd_addr_d = i_addr;
                        cmd_be_d   = {BE_W{1'b1}};
                    end
                end
            end
            S_ISSUE: begin
                last_owner_d = owner_q;
                if (owner_q == OWN_D) begin
                    d_cnt_d = d_cnt_q + 16'(d_cnt_q != 16'hFFFF);
                end else begin
                    i_cnt_d = i_cnt_q + 16'(i_cnt_q != 16'hFFFF);
                end
                if (cmd_we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = LAT_M1;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = S_RESP;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_be_q     <= '0;
            wait_cnt_q   <= 3'd0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_cnt_q      <= 16'd0;
            d_cnt_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_be_q     <= cmd_be_d;
            wait_cnt_q   <= wait_cnt_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_cnt_q      <= i_cnt_d;
            d_cnt_q      <= d_cnt_d;
        end
    end

    assign mem_cs    = (state_q == S_ISSUE);
    assign mem_we    = mem_cs & cmd_we_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign mem_be    = cmd_be_q;
    assign i_gnt     = mem_cs & (owner_q == OWN_I);
    assign d_gnt     = mem_cs & (owner_q == OWN_D);
    assign i_rvalid  = (state_q == S_RESP) & (owner_q == OWN_I);
    assign d_rvalid  = (state_q == S_RESP) & (owner_q == OWN_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign i_cnt     = i_cnt_q;
    assign d_cnt     = d_cnt_q;

endmodule
